// File: rtl/reg_display.sv
// Register-file viewer: steps a debug register index by buttons or timer, shadows
// the returned value and scans it as 8 hex digits onto a multiplexed 7-segment display.
module reg_display #(
  parameter int SCAN_DIV = 1000,
  parameter int STEP_DIV = 50000000,
  parameter int DEBOUNCE = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic        auto_en,
  input  logic        freeze,
  output logic [4:0]  reg_out_id,
  input  logic [31:0] reg_out_data,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        dp
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STEP_W = $clog2(STEP_DIV);
  localparam int DEB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // bit 0 = next, bit 1 = prev
  logic [1:0]       r_sync1, r_sync2, r_prev;
  logic [DEB_W-1:0] r_lock [2];
  logic [1:0]       w_btn, w_edge, w_acc;

  logic [4:0]        r_id;
  logic [STEP_W-1:0] r_step;
  logic [31:0]       r_shadow;
  logic              w_auto_step;

  logic [SCAN_W-1:0] r_scan;
  logic [2:0]        r_digit;
  logic [3:0]        w_nibble;
  logic [6:0]        r_seg;
  logic [7:0]        r_an;
  logic              r_dp;

  assign w_btn  = {btn_prev, btn_next};
  assign w_edge = r_sync2 & ~r_prev;
  // Frozen edges are dropped rather than deferred; lockouts keep counting down.
  assign w_acc[0] = w_edge[0] & (r_lock[0] == '0) & ~freeze;
  assign w_acc[1] = w_edge[1] & (r_lock[1] == '0) & ~freeze;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_lock[0] <= '0;
      r_lock[1] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      for (int i = 0; i < 2; i++) begin
        if (w_acc[i])
          r_lock[i] <= DEB_W'(DEBOUNCE - 1);
        else if (r_lock[i] != '0)
          r_lock[i] <= r_lock[i] - 1'b1;
      end
    end
  end

  assign w_auto_step = auto_en & (r_step == STEP_W'(STEP_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_id     <= '0;
      r_step   <= '0;
      r_shadow <= '0;
    end else if (!freeze) begin
      r_shadow <= reg_out_data;
      // A button step wins over a coincident auto step and restarts the timer.
      if (w_acc != 2'b00) begin
        r_step <= '0;
        if (w_acc == 2'b01)
          r_id <= r_id + 5'd1;
        else if (w_acc == 2'b10)
          r_id <= r_id - 5'd1;
      end else if (!auto_en) begin
        r_step <= '0;
      end else if (w_auto_step) begin
        r_step <= '0;
        r_id   <= r_id + 5'd1;
      end else begin
        r_step <= r_step + 1'b1;
      end
    end
  end

  assign w_nibble = r_shadow[{r_digit, 2'b00} +: 4];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_scan  <= '0;
      r_digit <= '0;
      r_seg   <= 7'b1000000;
      r_an    <= 8'b1111_1110;
      r_dp    <= 1'b1;
    end else begin
      if (r_scan == SCAN_W'(SCAN_DIV - 1)) begin
        r_scan  <= '0;
        r_digit <= r_digit + 3'd1;
      end else begin
        r_scan <= r_scan + 1'b1;
      end
      r_seg <= hex7(w_nibble);
      r_an  <= ~(8'b0000_0001 << r_digit);
      r_dp  <= ~((r_digit == 3'd7) & freeze);
    end
  end

  assign reg_out_id = r_id;
  assign seg        = r_seg;
  assign an         = r_an;
  assign dp         = r_dp;

endmodule

// File: tb/tb_reg_display.sv
// Directed bench for reg_display: buttons, lockout, auto-advance, scan order,
// freeze and reset, with reg_out_data served from a bench-owned table.
module tb_reg_display;

  logic        clock = 1'b0;
  logic        reset, btn_next, btn_prev, auto_en, freeze;
  logic [4:0]  reg_out_id;
  logic [31:0] reg_out_data;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        dp;

  logic [31:0] data_tab [32];
  int n_checks = 0;
  int n_fail   = 0;

  assign reg_out_data = data_tab[reg_out_id];

  always #5 clock = ~clock;

  reg_display #(.SCAN_DIV(4), .STEP_DIV(16), .DEBOUNCE(8)) dut (
    .clock(clock), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
    .auto_en(auto_en), .freeze(freeze), .reg_out_id(reg_out_id),
    .reg_out_data(reg_out_data), .seg(seg), .an(an), .dp(dp)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse(input logic nxt, input logic prv);
    btn_next = nxt;
    btn_prev = prv;
    tick();
    btn_next = 1'b0;
    btn_prev = 1'b0;
  endtask

  // one press, then enough idle cycles for acceptance and lockout expiry
  task automatic press(input logic nxt, input logic prv);
    pulse(nxt, prv);
    tick(12);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[nib];
  endfunction

  // Align to the first cycle of digit 0, then check a whole frame cycle by cycle.
  task automatic scan_frame(input string tag, input logic [31:0] val, input logic frz);
    logic [7:0] last;
    logic       found;
    int         d;
    found = 1'b0;
    last  = an;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (an == 8'b1111_1110 && last == 8'b0111_1111) found = 1'b1;
      else last = an;
    end
    check({tag, "_align"}, {31'd0, found}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      d = i / 4;
      check({tag, "_an"}, {24'd0, an}, {24'd0, ~(8'b0000_0001 << d)});
      check({tag, "_seg"}, {25'd0, seg}, {25'd0, seg_of(val[4*d +: 4])});
      check({tag, "_dp"}, {31'd0, dp}, {31'd0, ~(frz && d == 7)});
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) data_tab[k] = {4{k[4:0], 3'b101}};
    data_tab[1]  = 32'hDEADBEEF;
    reset = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; auto_en = 1'b0; freeze = 1'b0;
    tick(3);

    // reset values
    check("rst_id",  {27'd0, reg_out_id}, 32'd0);
    check("rst_an",  {24'd0, an},  {24'd0, 8'b1111_1110});
    check("rst_seg", {25'd0, seg}, {25'd0, 7'b1000000});
    check("rst_dp",  {31'd0, dp},  32'd1);
    reset = 1'b0;
    tick(2);

    // single next press: id changes two edges after the sampled pulse
    pulse(1'b1, 1'b0);
    tick();
    check("lat_early", {27'd0, reg_out_id}, 32'd0);
    tick();
    check("lat_id", {27'd0, reg_out_id}, 32'd1);
    tick(10);
    scan_frame("shadow1", 32'hDEADBEEF, 1'b0);

    // wrap both ways, then lockout on a second pulse 3 cycles later
    press(1'b0, 1'b1);
    check("prev_to0", {27'd0, reg_out_id}, 32'd0);
    press(1'b0, 1'b1);
    check("wrap_prev", {27'd0, reg_out_id}, 32'd31);
    press(1'b1, 1'b0);
    check("wrap_next", {27'd0, reg_out_id}, 32'd0);
    pulse(1'b1, 1'b0);
    tick(2);
    pulse(1'b1, 1'b0);
    tick(12);
    check("lockout", {27'd0, reg_out_id}, 32'd1);

    // simultaneous press, retry at +5 (locked), next at +10 (accepted)
    pulse(1'b1, 1'b1);
    tick(4);
    pulse(1'b1, 1'b1);
    tick(4);
    check("simul_hold", {27'd0, reg_out_id}, 32'd1);
    pulse(1'b1, 1'b0);
    tick(3);
    check("after_lock", {27'd0, reg_out_id}, 32'd2);
    tick(10);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("pre_auto", {27'd0, reg_out_id}, 32'd5);

    // auto-advance every 16 cycles, restarted by a button press
    auto_en = 1'b1;
    for (int s = 6; s <= 8; s++) begin
      tick(15);
      check("auto_before", {27'd0, reg_out_id}, 32'(s - 1));
      tick();
      check("auto_step", {27'd0, reg_out_id}, 32'(s));
    end
    tick(7);
    pulse(1'b1, 1'b0);
    tick(2);
    check("auto_btn", {27'd0, reg_out_id}, 32'd9);
    tick(15);
    check("auto_restart_hold", {27'd0, reg_out_id}, 32'd9);
    tick();
    check("auto_restart_step", {27'd0, reg_out_id}, 32'd10);
    auto_en = 1'b0;
    tick(2);

    // scan order for a known shadow value
    data_tab[10] = 32'h0123ABCD;
    scan_frame("scan", 32'h0123ABCD, 1'b0);

    // freeze holds id and shadow; dp marks digit 7
    freeze = 1'b1;
    tick();
    data_tab[10] = 32'h55667788;
    data_tab[11] = 32'h99999999;
    press(1'b1, 1'b0);
    check("frz_id", {27'd0, reg_out_id}, 32'd10);
    scan_frame("frz", 32'h0123ABCD, 1'b1);
    freeze = 1'b0;
    tick();
    scan_frame("unfrz", 32'h55667788, 1'b0);
    check("unfrz_id", {27'd0, reg_out_id}, 32'd10);

    // reset mid-operation
    reset = 1'b1;
    tick();
    check("mid_rst_id",  {27'd0, reg_out_id}, 32'd0);
    check("mid_rst_an",  {24'd0, an},  {24'd0, 8'b1111_1110});
    check("mid_rst_seg", {25'd0, seg}, {25'd0, 7'b1000000});
    check("mid_rst_dp",  {31'd0, dp},  32'd1);
    reset = 1'b0;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_display.md
# reg_display

Register-file viewer for the board's 7-segment displays. Sits directly downstream of the `Riscv` core's debug port: it drives `reg_out_id`, captures the returned `reg_out_data` into a shadow register, and shows it as 8 hex digits on a time-multiplexed display. The register id is stepped by push-buttons or by an auto-advance timer.

## Interface
- SCAN_DIV, 1000: clock cycles each digit stays enabled; ≥1.
- STEP_DIV, 50000000: clock cycles between auto-advance steps; ≥2.
- DEBOUNCE, 1000000: lockout cycles after an accepted button press; ≥1.

- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- btn_next  in  1  raw push-button level; rising edge steps id +1.
- btn_prev  in  1  raw push-button level; rising edge steps id −1.
- auto_en  in  1  level; enables auto-advance.
- freeze  in  1  level; holds the shadow register and all id changes.
- reg_out_id  out  5  register index presented to the core.
- reg_out_data  in  32  register value returned by the core, combinational in `reg_out_id`.
- seg  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- an  out  8  active-low digit enables, one-hot; an[k] is digit k, with digit 0 least significant.
- dp  out  1  active-low decimal point.

## Operation
- **Button path:**
  - Each button passes through a 2-flop synchronizer, then a registered previous-value flop.
  - An edge is defined as sync2 & ~prev.
  - Each button has its own lockout counter. An edge is accepted only when that counter is 0; acceptance loads the counter with DEBOUNCE−1, and it then decrements to 0.
  - Edges during lockout are discarded.
- **Id counter (5-bit):**
  - Accepted next: +1, wrapping 31→0.
  - Accepted prev: −1, wrapping 0→31.
  - Accepted next and prev in the same cycle: id unchanged, and both lockouts load.
- **Auto-advance:**
  - Step counter counts 0..STEP_DIV−1 while auto_en=1 and freeze=0.
  - On the count STEP_DIV−1 it wraps to 0 and id +1 (wrap 31→0).
  - The counter clears to 0 when auto_en=0 and in any cycle with an accepted button edge. A button step takes priority over an auto step in the same cycle.
- **Freeze:**
  - While freeze=1, id, shadow and step counter hold.
  - Button edges are discarded while freeze=1, but lockout counters still run.
  - Scan continues.
- **Shadow register (32-bit):** loads reg_out_data every cycle that freeze=0.
- **Scan:**
  - Divider counts 0..SCAN_DIV−1. On wrap, the digit index (3-bit) increments, wrapping 7→0.
  - an = ~(1<<digit).
  - seg = hex7(shadow[4·digit+3 : 4·digit]).
- **Hex encoding (active-low {g..a}):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **dp:** 0 only when digit==7 and freeze=1; 1 otherwise.
- **Registered outputs:** seg, an and dp are registered from digit/shadow state, so there are no combinational paths from inputs to outputs.
- **Reset:** clears every register in the block.

## Timing
- **Reset values:**
  - reg_out_id=0, shadow=0, digit=0.
  - an=11111110, seg=1000000, dp=1.
  - All counters, synchronizers and previous-value flops are 0.
- **Button latency:** btn_next high, first sampled at edge N → reg_out_id updates at edge N+2.
- **Shadow latency:**
  - Shadow reflects the new id's data at edge N+3.
  - seg/an reflect the shadow one edge later (N+4), when that digit is active.
- **Auto-step period:** exactly STEP_DIV cycles between id changes, measured from the first cycle with auto_en=1.
- **Digit period:**
  - Each digit is enabled for exactly SCAN_DIV cycles.
  - A full frame is 8·SCAN_DIV cycles.
- **Reset mid-operation:** asserting reset in any cycle yields the reset values at the next edge. A button held high through reset does not produce a step after reset, because the synchronizer and previous-value flops all clear together.

## Test plan
Use SCAN_DIV=4, STEP_DIV=16, DEBOUNCE=8 for all scenarios.
1. **Reset:** check the reset values. Then pulse btn_next for 1 cycle → reg_out_id=1 two edges after the pulse; the shadow then captures the model's value, 0xDEADBEEF for x1.
2. **Wrap:** from id 0, pulse btn_prev → id=31. Then pulse btn_next → id=0. Pulses 3 cycles apart within lockout → only the first is accepted.
3. **Simultaneous buttons:** btn_next and btn_prev rise in the same cycle → id unchanged; a further pulse 5 cycles later is ignored; a pulse 10 cycles later is accepted.
4. **Auto-advance:** auto_en=1 from id 5 → id 6, 7, 8 at 16-cycle intervals. A btn_next press at cycle 10 → id +1 and the step counter restarts, so the next auto step comes 16 cycles later.
5. **Scan:** shadow=0x0123ABCD → each an pattern persists for 4 cycles in order 11111110 … 01111111. seg sequence is d, C, b, A, 3, 2, 1, 0 = 0100001, 1000110, 0000011, 0001000, 0110000, 0100100, 1111001, 1000000.
6. **Freeze:** freeze=1 while reg_out_data changes and btn_next pulses → id and shadow hold, and dp=0 only while an=01111111. Release freeze → shadow updates on the next edge.
